// File: rtl/iter_counter.sv
// -----------------------------------------------------------------------------
// iter_counter
// Parametrised iteration counter used by multi-cycle datapath controllers
// (shift-add multiplier, restoring divider, ...). A load starts a run that
// counts up from 0 to the latched limit, or down from the limit to 0. The run
// either saturates at the terminal count or, with AUTO_RELOAD=1, restarts
// automatically while enabled.
//
// Parameters:
//   WIDTH        counter / limit width in bits (2..16)
//   RESET_LIMIT  terminal limit held after reset (must fit in WIDTH bits)
//   AUTO_RELOAD  0 = saturate at terminal, 1 = restart at terminal when enabled
//
// Ports:
//   clk_i        clock, rising edge
//   rst_n_i      asynchronous active-low reset
//   load_i       synchronous start/restart, latches limit_i and mode_down_i
//   en_i         count enable, low stalls the count
//   mode_down_i  direction, sampled with load_i (0 = up, 1 = down)
//   limit_i      terminal value, sampled with load_i
//   count_o      current count (registered)
//   k_o          terminal reached (level)
//   k_pulse_o    one-cycle pulse on the rising edge of k_o
//   busy_o       inverse of k_o
// -----------------------------------------------------------------------------
module iter_counter #(
    parameter int unsigned WIDTH       = 6,
    parameter int unsigned RESET_LIMIT = 30,
    parameter bit          AUTO_RELOAD = 1'b0
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             load_i,
    input  logic             en_i,
    input  logic             mode_down_i,
    input  logic [WIDTH-1:0] limit_i,
    output logic [WIDTH-1:0] count_o,
    output logic             k_o,
    output logic             k_pulse_o,
    output logic             busy_o
);

    localparam logic [WIDTH-1:0] RST_LIMIT = WIDTH'(RESET_LIMIT);
    localparam logic [WIDTH-1:0] ONE       = WIDTH'(1);

    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] limit_q, limit_d;
    logic             mode_q, mode_d;
    logic             k_dly_q;
    logic             k_term;

    // Terminal decode looks only at registered state so that k_o is glitch
    // free and independent of the live limit_i / mode_down_i inputs.
    always_comb begin
        if (mode_q) begin
            k_term = (count_q == '0);
        end else begin
            k_term = (count_q == limit_q);
        end
    end

    always_comb begin
        count_d = count_q;
        limit_d = limit_q;
        mode_d  = mode_q;
        if (load_i) begin
            limit_d = limit_i;
            mode_d  = mode_down_i;
            count_d = mode_down_i ? limit_i : '0;
        end else if (en_i) begin
            if (!k_term) begin
                count_d = mode_q ? (count_q - ONE) : (count_q + ONE);
            end else if (AUTO_RELOAD) begin
                // Restart value is the start point of the current direction;
                // with a limit of 0 this equals the terminal, so k_o stays high.
                count_d = mode_q ? limit_q : '0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            count_q <= '0;
            limit_q <= RST_LIMIT;
            mode_q  <= 1'b0;
            k_dly_q <= 1'b1;
        end else begin
            count_q <= count_d;
            limit_q <= limit_d;
            mode_q  <= mode_d;
            k_dly_q <= k_term;
        end
    end

    // k_dly_q resets high so no pulse appears straight out of reset.
    assign count_o   = count_q;
    assign k_o       = k_term;
    assign k_pulse_o = k_term & ~k_dly_q;
    assign busy_o    = ~k_term;

endmodule

// File: tb/tb_iter_counter.sv
// -----------------------------------------------------------------------------
// tb_iter_counter
// Directed bench for iter_counter. dut_a: WIDTH=6, RESET_LIMIT=30, saturating.
// dut_b: WIDTH=4, RESET_LIMIT=15, auto-reload. Inputs change 1 ns after the
// rising edge, outputs are sampled at the same point.
// -----------------------------------------------------------------------------
module tb_iter_counter;

    logic       clk = 1'b0;
    logic       rst_n;

    logic       load_a, en_a, mode_a;
    logic [5:0] limit_a, count_a;
    logic       k_a, kp_a, busy_a;

    logic       load_b, en_b, mode_b;
    logic [3:0] limit_b, count_b;
    logic       k_b, kp_b, busy_b;

    int checks = 0;
    int errs   = 0;

    always #5 clk = ~clk;

    iter_counter #(.WIDTH(6), .RESET_LIMIT(30), .AUTO_RELOAD(1'b0)) dut_a (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .load_i      (load_a),
        .en_i        (en_a),
        .mode_down_i (mode_a),
        .limit_i     (limit_a),
        .count_o     (count_a),
        .k_o         (k_a),
        .k_pulse_o   (kp_a),
        .busy_o      (busy_a)
    );

    iter_counter #(.WIDTH(4), .RESET_LIMIT(15), .AUTO_RELOAD(1'b1)) dut_b (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .load_i      (load_b),
        .en_i        (en_b),
        .mode_down_i (mode_b),
        .limit_i     (limit_b),
        .count_o     (count_b),
        .k_o         (k_b),
        .k_pulse_o   (kp_b),
        .busy_o      (busy_b)
    );

    task automatic check_val(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_a(input string tag, input int cnt, input int k, input int kp);
        check_val({tag, ".count"}, int'(count_a), cnt);
        check_val({tag, ".k"},     int'(k_a),     k);
        check_val({tag, ".kp"},    int'(kp_a),    kp);
        check_val({tag, ".busy"},  int'(busy_a),  1 - k);
    endtask

    initial begin : stim
        int en_seq [7]  = '{1, 0, 1, 1, 0, 1, 1};
        int cnt_seq [7] = '{4, 4, 3, 2, 2, 1, 0};
        int pulses;
        int last_pulse;

        rst_n   = 1'b0;
        load_a  = 1'b0; en_a = 1'b0; mode_a = 1'b0; limit_a = '0;
        load_b  = 1'b0; en_b = 1'b0; mode_b = 1'b0; limit_b = '0;
        #12;
        check_a("rst_init", 0, 0, 0);
        check_val("rst_init_b.k", int'(k_b), 0);
        rst_n = 1'b1;
        en_a  = 1'b1;

        // ---- reset mid-count, then up to RESET_LIMIT ----
        for (int i = 1; i <= 7; i++) tick();
        check_val("pre_rst.count", int'(count_a), 7);
        #2;
        rst_n = 1'b0;
        #1;
        check_a("async_rst", 0, 0, 0);
        #1;
        rst_n = 1'b1;
        for (int i = 1; i <= 29; i++) tick();
        check_a("rst_run29", 29, 0, 0);
        tick();
        check_a("rst_run30", 30, 1, 1);
        tick();
        check_a("rst_run31", 30, 1, 0);

        // ---- up run to 12, limit/mode changes without load are ignored ----
        load_a = 1'b1; limit_a = 6'd12; mode_a = 1'b0;
        tick();
        check_a("up_load", 0, 0, 0);
        load_a = 1'b0; limit_a = 6'd3; mode_a = 1'b1;
        for (int i = 1; i <= 11; i++) tick();
        check_a("up_11", 11, 0, 0);
        tick();
        check_a("up_12", 12, 1, 1);
        tick();
        check_a("up_13", 12, 1, 0);
        tick();
        check_a("up_14", 12, 1, 0);

        // ---- down run with stalls ----
        load_a = 1'b1; limit_a = 6'd5; mode_a = 1'b1;
        tick();
        check_a("dn_load", 5, 0, 0);
        load_a = 1'b0;
        for (int i = 0; i < 7; i++) begin
            en_a = en_seq[i][0];
            tick();
            check_val($sformatf("dn_%0d.count", i), int'(count_a), cnt_seq[i]);
            check_val($sformatf("dn_%0d.k", i), int'(k_a), (i == 6) ? 1 : 0);
        end
        check_val("dn_end.kp", int'(kp_a), 1);
        en_a = 1'b1;
        tick();
        check_a("dn_hold", 0, 1, 0);

        // ---- load priority over enable ----
        load_a = 1'b1; en_a = 1'b1; limit_a = 6'd9; mode_a = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_a($sformatf("prio_%0d", i), 0, 0, 0);
        end
        load_a = 1'b0;
        tick();
        check_a("prio_c1", 1, 0, 0);
        for (int i = 2; i <= 8; i++) tick();
        check_a("prio_c8", 8, 0, 0);
        tick();
        check_a("prio_c9", 9, 1, 1);

        // ---- limit 0, then restart while K is high ----
        load_a = 1'b1; limit_a = 6'd9;
        tick();
        check_a("z_prep", 0, 0, 0);
        limit_a = 6'd0;
        tick();
        check_a("z_load", 0, 1, 1);
        load_a = 1'b0;
        tick();
        check_a("z_hold", 0, 1, 0);
        load_a = 1'b1; limit_a = 6'd3;
        tick();
        check_a("re_load", 0, 0, 0);
        load_a = 1'b0;
        tick();
        tick();
        check_a("re_2", 2, 0, 0);
        tick();
        check_a("re_3", 3, 1, 1);

        // ---- auto-reload, WIDTH=4, limit 15 ----
        load_b = 1'b1; limit_b = 4'd15; mode_b = 1'b0; en_b = 1'b1;
        tick();
        check_val("ar_load.count", int'(count_b), 0);
        load_b     = 1'b0;
        pulses     = 0;
        last_pulse = -1;
        for (int t = 1; t <= 48; t++) begin
            tick();
            if (t == 15) check_val("ar_t15.count", int'(count_b), 15);
            if (t == 16) check_val("ar_t16.count", int'(count_b), 0);
            if (t == 16) check_val("ar_t16.k", int'(k_b), 0);
            if (kp_b) begin
                pulses++;
                if (last_pulse < 0) check_val("ar_first_pulse", t, 15);
                else                check_val("ar_spacing", t - last_pulse, 16);
                last_pulse = t;
            end
        end
        check_val("ar_pulses", pulses, 3);

        // auto-reload with limit 0: K stays high, single pulse
        load_b = 1'b1; limit_b = 4'd0;
        tick();
        check_val("ar0_load.k", int'(k_b), 1);
        check_val("ar0_load.kp", int'(kp_b), 1);
        load_b = 1'b0;
        pulses = 0;
        for (int t = 0; t < 3; t++) begin
            tick();
            if (kp_b) pulses++;
        end
        check_val("ar0_k", int'(k_b), 1);
        check_val("ar0_count", int'(count_b), 0);
        check_val("ar0_pulses", pulses, 0);
        check_val("ar0_busy", int'(busy_b), 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected finish before 100000 ns");
        $fatal(1);
    end

endmodule
